// File: rtl/fetch_pkg.sv
// Shared definitions for the instruction fetch controller: FSM states,
// the canonical NOP encoding and the default reset PC.
package fetch_pkg;

    typedef enum logic [2:0] {
        ST_IDLE    = 3'd0,
        ST_FETCH   = 3'd1,
        ST_WAIT    = 3'd2,
        ST_DELIVER = 3'd3,
        ST_TRAP    = 3'd4
    } fetch_state_e;

    // addi x0, x0, 0
    localparam logic [31:0] NOP_INSTR        = 32'h0000_0013;
    localparam logic [31:0] DEFAULT_RESET_PC = 32'h0000_0000;

    // A PC is legal only when it is word aligned.
    function automatic logic pc_aligned(input logic [31:0] pc);
        return (pc[1:0] == 2'b00);
    endfunction

endpackage

// File: rtl/pc_fetch_ctrl.sv
// Program counter owner and instruction fetch sequencer for the single-cycle
// core. One request is outstanding at a time; the fetched word is held for
// decode until it retires, is redirected away, or a trap is taken.
module pc_fetch_ctrl
    import fetch_pkg::*;
#(
    parameter logic [31:0] RESET_PC = DEFAULT_RESET_PC
) (
    input  logic        clk,
    input  logic        rst,
    input  logic [31:0] NextoPC,
    output logic [31:0] fromPC,
    input  logic        redirect,
    input  logic [31:0] redirect_target,
    input  logic        stall,
    output logic        imem_req_valid,
    input  logic        imem_req_ready,
    output logic [31:0] imem_addr,
    input  logic        imem_rsp_valid,
    input  logic [31:0] imem_rsp_data,
    output logic [31:0] instr,
    output logic        instr_valid,
    output logic        misaligned,
    output logic [31:0] fetchCount
);

    fetch_state_e state_q, state_d;
    logic [31:0]  pc_q, pc_d;
    logic [31:0]  pend_q, pend_d;
    logic         flush_q, flush_d;
    logic [31:0]  instr_q, instr_d;
    logic [31:0]  count_q, count_d;
    logic [31:0]  flush_tgt;

    // Every output is a register or a decode of the state register, so the
    // memory request and the decode handshake never see combinational paths
    // from this cycle's inputs.
    assign fromPC         = pc_q;
    assign imem_addr      = pc_q;
    assign imem_req_valid = (state_q == ST_FETCH);
    assign instr_valid    = (state_q == ST_DELIVER);
    assign instr          = instr_q;
    assign misaligned     = (state_q == ST_TRAP);
    assign fetchCount     = count_q;

    // Next-state and datapath updates, defaults first.
    always_comb begin
        state_d   = state_q;
        pc_d      = pc_q;
        pend_d    = pend_q;
        flush_d   = flush_q;
        instr_d   = instr_q;
        count_d   = count_q;
        // A redirect arriving together with the response is the newest
        // target and wins over anything already pending.
        flush_tgt = redirect ? redirect_target : pend_q;

        unique case (state_q)
            ST_IDLE: begin
                state_d = ST_FETCH;
            end

            ST_FETCH: begin
                if (imem_req_ready) begin
                    // Request leaves with the old PC; a redirect now must
                    // squash the word that comes back.
                    state_d = ST_WAIT;
                    if (redirect) begin
                        pend_d  = redirect_target;
                        flush_d = 1'b1;
                    end
                end else if (redirect) begin
                    // Nothing issued yet, so simply retarget the request.
                    if (pc_aligned(redirect_target)) begin
                        pc_d = redirect_target;
                    end else begin
                        state_d = ST_TRAP;
                    end
                end
            end

            ST_WAIT: begin
                if (imem_rsp_valid) begin
                    if (flush_q || redirect) begin
                        flush_d = 1'b0;
                        if (pc_aligned(flush_tgt)) begin
                            pc_d    = flush_tgt;
                            state_d = ST_FETCH;
                        end else begin
                            state_d = ST_TRAP;
                        end
                    end else begin
                        instr_d = imem_rsp_data;
                        state_d = ST_DELIVER;
                    end
                end else if (redirect) begin
                    pend_d  = redirect_target;
                    flush_d = 1'b1;
                end
            end

            ST_DELIVER: begin
                // A misaligned target traps the branch instead of retiring
                // it, so the counter only advances on a legal PC load.
                if (redirect) begin
                    if (pc_aligned(redirect_target)) begin
                        pc_d    = redirect_target;
                        count_d = count_q + 32'd1;
                        state_d = ST_FETCH;
                    end else begin
                        state_d = ST_TRAP;
                    end
                end else if (!stall) begin
                    if (pc_aligned(NextoPC)) begin
                        pc_d    = NextoPC;
                        count_d = count_q + 32'd1;
                        state_d = ST_FETCH;
                    end else begin
                        state_d = ST_TRAP;
                    end
                end
            end

            ST_TRAP: begin
                state_d = ST_TRAP;
            end

            default: begin
                state_d = ST_IDLE;
            end
        endcase

        // The held word is only meaningful while it is being delivered.
        if (state_d != ST_DELIVER) begin
            instr_d = NOP_INSTR;
        end
        if (state_d == ST_TRAP) begin
            flush_d = 1'b0;
        end
    end

    // State registers with synchronous reset overriding everything.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= ST_IDLE;
            pc_q    <= RESET_PC;
            pend_q  <= '0;
            flush_q <= 1'b0;
            instr_q <= NOP_INSTR;
            count_q <= '0;
        end else begin
            state_q <= state_d;
            pc_q    <= pc_d;
            pend_q  <= pend_d;
            flush_q <= flush_d;
            instr_q <= instr_d;
            count_q <= count_d;
        end
    end

endmodule
